// File: rtl/trap_csr.sv
// Machine-mode trap CSR file: trap entry, mret, CSR instruction access and
// interrupt-line synchronisation into mip. M and U privilege only.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif
`ifndef INTR_LEN
`define INTR_LEN 32
`endif

module trap_csr #(
    parameter int              XLEN        = `XLEN,
    parameter int              ALEN        = `ALEN,
    parameter int              INTR_LEN    = `INTR_LEN,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csr_valid,
    input  logic [11:0]            csr_addr,
    input  logic [1:0]             csr_op,
    input  logic [XLEN-1:0]        csr_wdata,
    output logic [XLEN-1:0]        csr_rdata,
    output logic                   csr_illegal,
    input  logic                   trap_exception,
    input  logic [3:0]             exc_cause,
    input  logic                   take_m_int,
    input  logic [5:0]             int_cause,
    input  logic [ALEN-1:0]        trap_mepc,
    input  logic [XLEN-1:0]        trap_mtval,
    input  logic                   xret_commit,
    input  logic                   timer_irq,
    input  logic [INTR_LEN-17:0]   platform_irq,
    output logic [1:0]             privilege_mode,
    output logic [XLEN-1:0]        mstatus,
    output logic [XLEN-1:0]        mtvec,
    output logic [INTR_LEN-1:0]    mie,
    output logic [INTR_LEN-1:0]    mip,
    output logic [ALEN-1:0]        mepc
);

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    logic [1:0]           priv_q, priv_d;
    logic                 mstat_mie_q, mstat_mie_d;
    logic                 mpie_q, mpie_d;
    logic [1:0]           mpp_q, mpp_d;
    logic [INTR_LEN-1:0]  mie_q, mie_d;
    logic [XLEN-1:0]      mtvec_q, mtvec_d;
    logic [XLEN-1:0]      mscratch_q, mscratch_d;
    logic [ALEN-1:0]      mepc_q, mepc_d;
    logic [XLEN-1:0]      mcause_q, mcause_d;
    logic [XLEN-1:0]      mtval_q, mtval_d;
    logic                 timer_s1_q, timer_s1_d, timer_s2_q, timer_s2_d;
    logic [INTR_LEN-17:0] plat_s1_q, plat_s1_d, plat_s2_q, plat_s2_d;

    logic [XLEN-1:0]      mstatus_w;
    logic [INTR_LEN-1:0]  mip_w;
    logic [XLEN-1:0]      wval;
    logic                 mapped;
    logic                 csr_wr;
    logic                 trap;

    always_comb begin
        mstatus_w        = '0;
        mstatus_w[3]     = mstat_mie_q;
        mstatus_w[7]     = mpie_q;
        mstatus_w[12:11] = mpp_q;
        mip_w                = '0;
        mip_w[7]             = timer_s2_q;
        mip_w[INTR_LEN-1:16] = plat_s2_q;
    end

    // Read mux; csr_rdata is the pre-write value that RS/RC modify.
    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        case (csr_addr)
            12'h300: csr_rdata = mstatus_w;
            12'h304: csr_rdata = XLEN'(mie_q);
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = XLEN'(mepc_q);
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = XLEN'(mip_w);
            12'hF14: csr_rdata = '0;
            default: mapped    = 1'b0;
        endcase
        csr_illegal = csr_valid && (!mapped ||
                      (csr_op != 2'b00 && csr_addr[11:10] == 2'b11) ||
                      priv_q != PRIV_M);
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    assign trap   = trap_exception || take_m_int;
    assign csr_wr = csr_valid && !csr_illegal && csr_op != 2'b00 && !trap;

    // Applied in order mret -> trap -> CSR write, each stage seeing the previous.
    always_comb begin
        priv_d      = priv_q;
        mstat_mie_d = mstat_mie_q;
        mpie_d      = mpie_q;
        mpp_d       = mpp_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        timer_s1_d  = timer_irq;
        timer_s2_d  = timer_s1_q;
        plat_s1_d   = platform_irq;
        plat_s2_d   = plat_s1_q;

        if (xret_commit) begin
            priv_d      = mpp_q;
            mstat_mie_d = mpie_q;
            mpie_d      = 1'b1;
            mpp_d       = PRIV_U;
        end

        if (trap) begin
            if (trap_exception)
                mcause_d = {1'b0, (XLEN-1)'(exc_cause)};
            else
                mcause_d = {1'b1, (XLEN-1)'(int_cause)};
            mtval_d = trap_mtval;
            // An interrupt behind a completed mret keeps the mret's return target.
            if (!xret_commit)
                mepc_d = trap_mepc;
            mpie_d      = mstat_mie_d;
            mstat_mie_d = 1'b0;
            mpp_d       = priv_d;
            priv_d      = PRIV_M;
        end

        if (csr_wr) begin
            case (csr_addr)
                12'h300: begin
                    mstat_mie_d = wval[3];
                    mpie_d      = wval[7];
                    mpp_d       = (wval[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
                end
                12'h304: mie_d = INTR_LEN'(wval);
                12'h305: begin
                    mtvec_d    = wval;
                    mtvec_d[1] = 1'b0;
                end
                12'h340: mscratch_d = wval;
                12'h341: begin
                    mepc_d    = ALEN'(wval);
                    mepc_d[0] = 1'b0;
                end
                12'h342: mcause_d = wval;
                12'h343: mtval_d  = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            priv_q      <= PRIV_M;
            mstat_mie_q <= 1'b0;
            mpie_q      <= 1'b0;
            mpp_q       <= PRIV_U;
            mie_q       <= '0;
            mtvec_q     <= MTVEC_RESET;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            timer_s1_q  <= 1'b0;
            timer_s2_q  <= 1'b0;
            plat_s1_q   <= '0;
            plat_s2_q   <= '0;
        end else begin
            priv_q      <= priv_d;
            mstat_mie_q <= mstat_mie_d;
            mpie_q      <= mpie_d;
            mpp_q       <= mpp_d;
            mie_q       <= mie_d;
            mtvec_q     <= mtvec_d;
            mscratch_q  <= mscratch_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            timer_s1_q  <= timer_s1_d;
            timer_s2_q  <= timer_s2_d;
            plat_s1_q   <= plat_s1_d;
            plat_s2_q   <= plat_s2_d;
        end
    end

    assign privilege_mode = priv_q;
    assign mstatus        = mstatus_w;
    assign mtvec          = mtvec_q;
    assign mie            = mie_q;
    assign mip            = mip_w;
    assign mepc           = mepc_q;

endmodule

// File: tb/tb_trap_csr.sv
// Directed bench for trap_csr: reset, CSR access, trap/mret interplay,
// illegal-access filtering and interrupt synchroniser latency.
module tb_trap_csr;
    localparam int XLEN = 32;
    localparam int ALEN = 32;
    localparam int INTR_LEN = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_exception;
    logic [3:0]  exc_cause;
    logic        take_m_int;
    logic [5:0]  int_cause;
    logic [31:0] trap_mepc;
    logic [31:0] trap_mtval;
    logic        xret_commit;
    logic        timer_irq;
    logic [15:0] platform_irq;
    logic [1:0]  privilege_mode;
    logic [31:0] mstatus, mtvec, mie, mip, mepc;

    int tests = 0;
    int fails = 0;

    trap_csr #(.XLEN(XLEN), .ALEN(ALEN), .INTR_LEN(INTR_LEN), .MTVEC_RESET(MTVEC_RST)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_exception(trap_exception), .exc_cause(exc_cause), .take_m_int(take_m_int),
        .int_cause(int_cause), .trap_mepc(trap_mepc), .trap_mtval(trap_mtval),
        .xret_commit(xret_commit), .timer_irq(timer_irq), .platform_irq(platform_irq),
        .privilege_mode(privilege_mode), .mstatus(mstatus), .mtvec(mtvec), .mie(mie),
        .mip(mip), .mepc(mepc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_valid = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0;
        trap_exception = 0; exc_cause = 0; take_m_int = 0; int_cause = 0;
        trap_mepc = 0; trap_mtval = 0; xret_commit = 0;
    endtask

    // Drive a CSR access, let combinational outputs settle, leave commit to the caller.
    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_valid = 1; csr_addr = a; csr_op = op; csr_wdata = d;
        #1;
    endtask

    task automatic csr_commit(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr(a, op, d);
        step();
        idle();
    endtask

    initial begin
        rst = 1; timer_irq = 0; platform_irq = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_priv", {30'd0, privilege_mode}, 32'h3);
        chk("rst_mstatus", mstatus, 32'h0);
        chk("rst_mtvec", mtvec, MTVEC_RST);
        chk("rst_mip", mip, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        rst = 0;
        step();

        csr(12'h300, 2'b00, 0); chk("rd_mstatus", csr_rdata, 32'h0);
        chk("rd_mstatus_legal", {31'd0, csr_illegal}, 32'h0);
        csr(12'h305, 2'b00, 0); chk("rd_mtvec", csr_rdata, MTVEC_RST);
        csr(12'hF14, 2'b00, 0); chk("rd_mhartid", csr_rdata, 32'h0);
        chk("rd_mhartid_legal", {31'd0, csr_illegal}, 32'h0);
        idle();

        csr_commit(12'h300, 2'b01, 32'h0000_1888);
        chk("wr_mstatus", mstatus, 32'h0000_1888);
        csr_commit(12'h300, 2'b11, 32'h8);
        chk("rc_mstatus", mstatus, 32'h0000_1880);
        csr_commit(12'h300, 2'b01, 32'h0000_0800);
        chk("mpp_warl", mstatus, 32'h0);
        csr_commit(12'h305, 2'b01, 32'h0000_1003);
        chk("mtvec_bit1", mtvec, 32'h0000_1001);
        csr_commit(12'h341, 2'b01, 32'h0000_1235);
        chk("mepc_bit0", mepc, 32'h0000_1234);
        csr_commit(12'h340, 2'b01, 32'hAAAA_5555);
        csr(12'h340, 2'b10, 32'h0000_0F00);
        chk("rd_mscratch", csr_rdata, 32'hAAAA_5555);
        step(); idle();
        csr(12'h340, 2'b00, 0); chk("rs_mscratch", csr_rdata, 32'hAAAA_5F55);
        idle();

        // Enter U with MIE=1 via mret (MPIE=1, MPP=00).
        csr_commit(12'h300, 2'b01, 32'h0000_0080);
        xret_commit = 1; step(); idle();
        chk("mret_to_u_priv", {30'd0, privilege_mode}, 32'h0);
        chk("mret_to_u_mstatus", mstatus, 32'h0000_0088);

        csr(12'h300, 2'b00, 0); chk("u_read_illegal", {31'd0, csr_illegal}, 32'h1);
        step(); idle();
        csr_commit(12'h340, 2'b01, 32'h1111_1111);
        csr_commit(12'h300, 2'b01, 32'h0);
        chk("u_write_nochg", mstatus, 32'h0000_0088);

        trap_exception = 1; exc_cause = 4'd2; trap_mepc = 32'h1000; trap_mtval = 32'h13;
        step(); idle();
        chk("trap_mepc", mepc, 32'h1000);
        chk("trap_priv", {30'd0, privilege_mode}, 32'h3);
        chk("trap_mstatus", mstatus, 32'h0000_0080);
        csr(12'h342, 2'b00, 0); chk("trap_mcause", csr_rdata, 32'h2);
        csr(12'h343, 2'b00, 0); chk("trap_mtval", csr_rdata, 32'h13);
        csr(12'h340, 2'b00, 0); chk("u_mscratch_nochg", csr_rdata, 32'hAAAA_5F55);
        idle();

        xret_commit = 1; step(); idle();
        chk("mret_priv", {30'd0, privilege_mode}, 32'h0);
        chk("mret_mstatus", mstatus, 32'h0000_0088);

        trap_exception = 1; exc_cause = 4'd3; trap_mepc = 32'h2000; trap_mtval = 0;
        step(); idle();
        chk("trap2_mstatus", mstatus, 32'h0000_0080);
        xret_commit = 1; take_m_int = 1; int_cause = 6'd7; trap_mepc = 32'h3000;
        step(); idle();
        chk("mret_int_mepc", mepc, 32'h2000);
        chk("mret_int_mstatus", mstatus, 32'h0000_0080);
        chk("mret_int_priv", {30'd0, privilege_mode}, 32'h3);
        csr(12'h342, 2'b00, 0); chk("mret_int_mcause", csr_rdata, 32'h8000_0007);
        idle();

        csr(12'hF14, 2'b01, 32'h5); chk("wr_mhartid_illegal", {31'd0, csr_illegal}, 32'h1);
        step(); idle();
        csr(12'h7C0, 2'b01, 32'h5); chk("unmapped_illegal", {31'd0, csr_illegal}, 32'h1);
        step(); idle();
        chk("illegal_nochg", mstatus, 32'h0000_0080);

        csr(12'h340, 2'b01, 32'h2222_2222);
        trap_exception = 1; exc_cause = 4'd5; trap_mepc = 32'h4000; trap_mtval = 32'h44;
        #1; step(); idle();
        csr(12'h340, 2'b00, 0); chk("trap_drops_write", csr_rdata, 32'hAAAA_5F55);
        idle();

        // Back-to-back traps; exception wins over a simultaneous interrupt.
        trap_exception = 1; exc_cause = 4'd6; trap_mepc = 32'h5000; trap_mtval = 32'h55;
        step();
        exc_cause = 4'd9; take_m_int = 1; int_cause = 6'd3; trap_mepc = 32'h6000; trap_mtval = 32'h66;
        step(); idle();
        chk("b2b_mepc", mepc, 32'h6000);
        csr(12'h342, 2'b00, 0); chk("b2b_mcause", csr_rdata, 32'h9);
        csr(12'h343, 2'b00, 0); chk("b2b_mtval", csr_rdata, 32'h66);
        idle();

        platform_irq = 16'h0001; timer_irq = 1;
        step(); chk("irq_1edge", mip, 32'h0);
        step(); chk("irq_2edge", mip, 32'h0001_0080);
        csr_commit(12'h344, 2'b01, 32'h0);
        chk("mip_ro", mip, 32'h0001_0080);
        platform_irq = 0; timer_irq = 0;
        step(); chk("irq_deassert_1edge", mip, 32'h0001_0080);
        step(); chk("irq_deassert_2edge", mip, 32'h0);

        csr(12'h344, 2'b01, 32'h0); chk("mip_wr_legal", {31'd0, csr_illegal}, 32'h0);
        idle();

        csr_commit(12'h304, 2'b01, 32'h0001_0088);
        chk("mie_wr", mie, 32'h0001_0088);
        #2 rst = 1; #1;
        chk("async_rst_mepc", mepc, 32'h0);
        chk("async_rst_mie", mie, 32'h0);
        chk("async_rst_mtvec", mtvec, MTVEC_RST);
        step(); rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/trap_csr.md
# trap_csr

Machine-mode trap CSR file sitting directly downstream of the trap-decision logic in the exec/writeback path. It latches trap entry (mepc, mcause, mtval, mstatus stacking, privilege change), applies mret, services CSR-instruction reads and writes, and synchronises interrupt lines into mip. Its registered outputs (privilege_mode, mstatus, mie, mip, mtvec) feed back into the trap decision on the next cycle.

## Interface
- XLEN, default `XLEN: CSR data width.
- ALEN, default `ALEN: address width of mepc and trap_mepc.
- INTR_LEN, default `INTR_LEN: width of mie/mip; must be ≥17.
- MTVEC_RESET, default 0: reset value of mtvec.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- csr_valid  in  1  a CSR instruction retires this cycle.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 read, 01 write (RW), 10 set (RS), 11 clear (RC).
- csr_wdata  in  XLEN  operand for write/set/clear.
- csr_rdata  out  XLEN  combinational read of the current (pre-write) value.
- csr_illegal  out  1  combinational; the access must raise EXC_ILLEGAL_INSTR.
- trap_exception  in  1  an exception commits this cycle.
- exc_cause  in  4  exception code.
- take_m_int  in  1  an interrupt is taken this cycle.
- int_cause  in  6  interrupt code, without the interrupt bit.
- trap_mepc  in  ALEN  mepc value for trap entry.
- trap_mtval  in  XLEN  mtval value for trap entry.
- xret_commit  in  1  mret retires this cycle.
- timer_irq  in  1  async level, machine timer (mip bit 7).
- platform_irq  in  INTR_LEN-16  async levels, mip bits 16 and up.
- privilege_mode  out  2  current privilege: 00 U, 11 M.
- mstatus, mtvec  out  XLEN  each.
- mie, mip  out  INTR_LEN  each.
- mepc  out  ALEN  return target for mret.

## Operation
- Privilege support is M and U only.
- mstatus fields: MIE bit 3, MPIE bit 7, MPP bits 12:11. All other bits read 0.
- MPP is WARL: writes of 01 or 10 store 00.
- Address map:
  - 0x300 mstatus; 0x304 mie; 0x305 mtvec (bit 1 forced 0); 0x340 mscratch.
  - 0x341 mepc (bit 0 forced 0); 0x342 mcause (bit XLEN-1 is the interrupt flag); 0x343 mtval.
  - 0x344 mip: read-only; writes are ignored but legal.
  - 0xF14 mhartid: reads 0.
- csr_illegal when csr_valid and any of: address unmapped; op≠00 and addr[11:10]==11; privilege_mode≠M.
- Illegal accesses never modify state.
- Per-cycle update order: mret, then trap entry, then CSR write. A CSR write is dropped whenever trap_exception or take_m_int is high.
- mret: priv←MPP; MIE←MPIE; MPIE←1; MPP←00.
- Trap entry (trap_exception or take_m_int):
  - mcause←{take_m_int, zero-extended cause}.
  - mtval←trap_mtval; mepc←trap_mepc.
  - MPIE←MIE; MIE←0; MPP←priv; priv←11.
- Trap and mret in the same cycle (interrupt behind a completed mret):
  - mepc is NOT updated.
  - All other fields are computed from post-mret values: MPP←old MPP, MPIE←old MPIE, MIE←0, priv←11.
- trap_exception and take_m_int together is illegal upstream. The exception wins: mcause interrupt bit 0, exc_cause used.
- mip:
  - bit 7 = 2-flop synchronised timer_irq.
  - bits 16 and up = 2-flop synchronised platform_irq.
  - All other bits 0.

## Timing
- All state is written at the clk edge of the commit cycle and visible on outputs the next cycle.
- csr_rdata and csr_illegal have zero latency.
- An irq input edge reaches mip 2 edges later. Deassertion has the same latency.
- Reset values:
  - privilege_mode=11; mstatus=0; mie=0; mip=0; mtvec=MTVEC_RESET.
  - mepc=0; mcause=0; mtval=0; mscratch=0; synchroniser flops=0.
- Reset asserted mid-operation clears all state immediately (async) and discards any same-cycle commit.
- Back-to-back trap entries in consecutive cycles are each fully applied; the second overwrites the first.

## Test plan
- Reset, then read 0x300/0x305/0xF14 in M → 0, MTVEC_RESET, 0; privilege_mode=11.
- Write mstatus 0x0000_1888 then RC 0x8 → next-cycle mstatus=0x1880. Write MPP=01 → MPP reads 00.
- From U with MIE=1, trap_exception cause 2, trap_mepc 0x1000, trap_mtval 0x13 → mepc=0x1000, mcause=2, mtval=0x13, MPIE=1, MIE=0, MPP=00, priv=11. Then mret → priv=00, MIE=1, MPIE=1.
- Trap with mepc=0x2000, MPIE=1, MPP=00, then xret_commit and take_m_int(int_cause 7) together:
  - mepc stays 0x2000; mcause={1,7}; MPP=00; MPIE=1; MIE=0; priv=11.
- Raise platform_irq[0] → mip bit 16 set exactly 2 cycles later; timer_irq → bit 7 likewise; deassert → clears after 2 cycles.
- Illegal cases, each with no state change:
  - CSR write to 0xF14 → csr_illegal=1.
  - Access to 0x7C0 → csr_illegal=1.
  - Any access from U mode → csr_illegal=1.
  - csr_valid with trap_exception → write dropped.
